// File: rtl/square_add_accum.sv
// square_add_accum
//   Turns an interleaved multi-channel signed sample stream into one energy
//   value per sample index. Each group of CH_NUM samples is squared, summed,
//   shifted right by SHIFT, saturated to 16 bits and handed downstream over a
//   valid/ready handshake together with its SRAM address.
//
// Ports
//   i_50M_clk             system clock, rising edge
//   i_rst                 asynchronous active-high reset
//   i_start               frame start pulse, honoured only when idle
//   i_valid / i_sample    input sample stream (signed 16-bit)
//   o_in_ready            sample is accepted this cycle when i_valid is high
//   o_valid / i_ready     output word handshake
//   o_square_add_data_seq saturated non-negative result
//   o_SRAM_address        sample index of the current output
//   o_frame_done          one-cycle pulse after the last handshake of a frame
//   o_busy                high whenever not idle
module square_add_accum #(
   parameter int unsigned CH_NUM    = 4,
   parameter int unsigned SHIFT     = 10,
   parameter int unsigned FRAME_LEN = 1024,
   parameter int unsigned ADDR_W    = 20
) (
   input  logic                     i_50M_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic                     i_valid,
   input  logic signed [15:0]       i_sample,
   output logic                     o_in_ready,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic signed [15:0]       o_square_add_data_seq,
   output logic [ADDR_W-1:0]        o_SRAM_address,
   output logic                     o_frame_done,
   output logic                     o_busy
);

   localparam int unsigned CntW = $clog2(CH_NUM);
   localparam int unsigned AccW = 32 + CntW;

   typedef enum logic [1:0] {StIdle, StAccum, StFlush, StHold} state_e;

   state_e              state_q;
   logic [CntW-1:0]     ch_cnt_q;
   logic [31:0]         sq_q;
   logic                sq_vld_q;
   logic                sq_last_q;
   logic                add_last_q;
   logic [AccW-1:0]     acc_q;
   logic                valid_q;
   logic [15:0]         data_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                frame_done_q;

   logic signed [31:0]  prod;
   logic [AccW-1:0]     acc_shift;
   logic [15:0]         sat_data;

   // (-32768)^2 = 2^30 still fits a signed 32-bit product.
   assign prod = i_sample * i_sample;

   always_comb begin
      acc_shift = acc_q >> SHIFT;
      sat_data  = acc_shift[15:0];
      if (acc_shift > AccW'(32767)) begin
         sat_data = 16'h7fff;
      end
   end

   always_ff @(posedge i_50M_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= StIdle;
         ch_cnt_q     <= '0;
         sq_q         <= '0;
         sq_vld_q     <= 1'b0;
         sq_last_q    <= 1'b0;
         add_last_q   <= 1'b0;
         acc_q        <= '0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         addr_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         sq_vld_q     <= 1'b0;
         sq_last_q    <= 1'b0;
         add_last_q   <= 1'b0;
         frame_done_q <= 1'b0;

         // Second pipeline stage: fold the registered square into the sum.
         if (sq_vld_q) begin
            acc_q      <= acc_q + {{CntW{1'b0}}, sq_q};
            add_last_q <= sq_last_q;
         end

         unique case (state_q)
            StIdle: begin
               if (i_start) begin
                  state_q  <= StAccum;
                  addr_q   <= '0;
                  acc_q    <= '0;
                  ch_cnt_q <= '0;
               end
            end
            StAccum: begin
               if (i_valid) begin
                  sq_q     <= prod;
                  sq_vld_q <= 1'b1;
                  ch_cnt_q <= ch_cnt_q + 1'b1;
                  if (ch_cnt_q == CntW'(CH_NUM - 1)) begin
                     sq_last_q <= 1'b1;
                     state_q   <= StFlush;
                  end
               end
            end
            StFlush: begin
               // acc_q already holds the final product once add_last_q is set.
               if (add_last_q) begin
                  data_q  <= sat_data;
                  valid_q <= 1'b1;
                  state_q <= StHold;
               end
            end
            StHold: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  if (addr_q == ADDR_W'(FRAME_LEN - 1)) begin
                     frame_done_q <= 1'b1;
                     addr_q       <= '0;
                     state_q      <= StIdle;
                  end else begin
                     addr_q   <= addr_q + 1'b1;
                     acc_q    <= '0;
                     ch_cnt_q <= '0;
                     state_q  <= StAccum;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_in_ready            = (state_q == StAccum);
   assign o_busy                = (state_q != StIdle);
   assign o_valid               = valid_q;
   assign o_square_add_data_seq = data_q;
   assign o_SRAM_address        = addr_q;
   assign o_frame_done          = frame_done_q;

endmodule

// File: tb/tb_square_add_accum.sv
// tb_square_add_accum
//   Directed bench for square_add_accum. Two instances share the stimulus:
//   one with SHIFT=0 and one with SHIFT=10, both with FRAME_LEN=4 so that
//   address wrap and the frame-done pulse are reached quickly.
module tb_square_add_accum;

   localparam int unsigned ADDR_W = 20;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                valid;
   logic signed [15:0]  sample;
   logic                ready;

   logic                in_ready0, valid0, done0, busy0;
   logic signed [15:0]  data0;
   logic [ADDR_W-1:0]   addr0;
   logic                in_ready10, valid10, done10, busy10;
   logic signed [15:0]  data10;
   logic [ADDR_W-1:0]   addr10;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int done_base;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done0) done_cnt <= done_cnt + 1;
   end

   square_add_accum #(
      .CH_NUM(4), .SHIFT(0), .FRAME_LEN(4), .ADDR_W(ADDR_W)
   ) dut0 (
      .i_50M_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
      .i_sample(sample), .o_in_ready(in_ready0), .o_valid(valid0),
      .i_ready(ready), .o_square_add_data_seq(data0), .o_SRAM_address(addr0),
      .o_frame_done(done0), .o_busy(busy0)
   );

   square_add_accum #(
      .CH_NUM(4), .SHIFT(10), .FRAME_LEN(4), .ADDR_W(ADDR_W)
   ) dut10 (
      .i_50M_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
      .i_sample(sample), .o_in_ready(in_ready10), .o_valid(valid10),
      .i_ready(ready), .o_square_add_data_seq(data10), .o_SRAM_address(addr10),
      .o_frame_done(done10), .o_busy(busy10)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Returns one cycle after the edge that accepted the sample.
   task automatic send(input logic signed [15:0] v);
      int n;
      n      = 0;
      valid  = 1'b1;
      sample = v;
      while (!in_ready0 && n < 20) begin
         step();
         n++;
      end
      check_eq("send_ready", in_ready0, 1'b1);
      step();
      valid = 1'b0;
   endtask

   task automatic send_group(input logic signed [15:0] a, input logic signed [15:0] b,
                             input logic signed [15:0] c, input logic signed [15:0] d);
      send(a);
      send(b);
      send(c);
      send(d);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!valid0 && n < 20) begin
         step();
         n++;
      end
      check_eq("wait_valid", valid0, 1'b1);
   endtask

   // Latency: low after the accept edge and the next edge, high after the second.
   task automatic check_latency(input string tag);
      check_eq({tag, "_lat0"}, valid0, 1'b0);
      step();
      check_eq({tag, "_lat1"}, valid0, 1'b0);
      step();
      check_eq({tag, "_lat2"}, valid0, 1'b1);
      check_eq({tag, "_lat2_s10"}, valid10, 1'b1);
   endtask

   task automatic handshake(input string tag, input logic [15:0] exp0,
                            input logic [15:0] exp10, input logic [31:0] exp_addr,
                            input logic exp_done);
      check_eq({tag, "_valid"}, valid0, 1'b1);
      check_eq({tag, "_data_s0"}, 32'(data0), 32'(exp0));
      check_eq({tag, "_data_s10"}, 32'(data10), 32'(exp10));
      check_eq({tag, "_addr"}, addr0, exp_addr);
      check_eq({tag, "_addr_s10"}, addr10, exp_addr);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check_eq({tag, "_done"}, done0, exp_done);
      check_eq({tag, "_valid_drop"}, valid0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_valid"}, valid0, 1'b0);
      check_eq({tag, "_in_ready"}, in_ready0, 1'b0);
      check_eq({tag, "_busy"}, busy0, 1'b0);
      check_eq({tag, "_done"}, done0, 1'b0);
      check_eq({tag, "_data"}, 32'(data0), 32'd0);
      check_eq({tag, "_addr"}, addr0, 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      valid  = 1'b0;
      sample = '0;
      ready  = 1'b0;
      #1;
      check_all_zero("reset");
      step();
      step();
      rst = 1'b0;

      // Frame A
      done_base = done_cnt;
      pulse_start();
      check_eq("start_busy", busy0, 1'b1);
      check_eq("start_in_ready", in_ready0, 1'b1);

      send_group(16'sd1, 16'sd2, 16'sd3, -16'sd4);
      check_latency("g0");
      handshake("g0", 16'd30, 16'd0, 0, 1'b0);

      send_group(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
      wait_valid();
      // Backpressure: offered samples must not be consumed.
      valid  = 1'b1;
      sample = 16'sd9;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", valid0, 1'b1);
         check_eq("bp_data_s0", 32'(data0), 32'd32767);
         check_eq("bp_data_s10", 32'(data10), 32'd32767);
         check_eq("bp_addr", addr0, 32'd1);
         check_eq("bp_in_ready", in_ready0, 1'b0);
         step();
      end
      valid = 1'b0;
      handshake("g1", 16'd32767, 16'd32767, 1, 1'b0);

      send_group(16'sd100, 16'sd100, 16'sd100, 16'sd100);
      wait_valid();
      handshake("g2", 16'd32767, 16'd39, 2, 1'b0);

      // i_valid toggles within the group.
      for (int i = 0; i < 4; i++) begin
         send(16'sd3);
         if (i < 3) step();
      end
      check_latency("g3");
      handshake("g3", 16'd36, 16'd0, 3, 1'b1);
      check_eq("idle_busy", busy0, 1'b0);
      check_eq("idle_in_ready", in_ready0, 1'b0);
      check_eq("idle_addr", addr0, 32'd0);
      step();
      check_eq("done_pulses", 32'(done_cnt - done_base), 32'd1);

      // Samples while idle are ignored.
      valid  = 1'b1;
      sample = 16'sd50;
      for (int i = 0; i < 3; i++) begin
         check_eq("ign_in_ready", in_ready0, 1'b0);
         check_eq("ign_valid", valid0, 1'b0);
         check_eq("ign_busy", busy0, 1'b0);
         step();
      end
      valid = 1'b0;

      // Frame B: restarts at address 0, then reset mid-group at address 1.
      pulse_start();
      send_group(16'sd7, 16'sd0, 16'sd0, 16'sd0);
      wait_valid();
      handshake("b0", 16'd49, 16'd0, 0, 1'b0);
      send(16'sd5);
      send(16'sd5);
      check_eq("pre_rst_addr", addr0, 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      step();
      rst = 1'b0;
      pulse_start();
      send_group(16'sd5, 16'sd0, 16'sd0, 16'sd0);
      wait_valid();
      handshake("post_rst", 16'd25, 16'd0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
